sync_frame_tx: RTL and testbench
================================

# sync_frame_tx

Serial frame transmitter that emits a fixed sync word followed by a parallel-loaded payload and an even-parity bit, one bit per clock, on a single serial line. It is the sending end for the team's 1101 sequence detector: the detector recognises the sync word on this block's `tx` output and flags the start of a frame. It sits between a parallel producer, which uses a start/ready handshake, and the serial link.

## Interface
Parameters:
- `DATA_W`, default 8: payload width in bits, legal range 1..32.
- `SYNC_W`, default 4: sync word width, legal range 2..8.
- `SYNC`, default 4'b1101: sync word, transmitted MSB first.
- `IDLE_BIT`, default 1'b0: level driven on `tx` when no frame is in progress.

Ports:
- `clk`  in  1  clock, all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  request to send a frame; sampled only when `ready`=1.
- `data`  in  DATA_W  payload; captured on the edge that accepts `start`.
- `ready`  out  1  block can accept `start` this cycle.
- `busy`  out  1  a frame is being transmitted.
- `tx`  out  1  serial output, registered.
- `tx_valid`  out  1  `tx` carries a frame bit this cycle, registered.
- `done`  out  1  one-cycle pulse, coincident with the parity bit on `tx`.
- `state`  out  2  current FSM state, for debug and verification.

## Operation
- FSM states:
  - IDLE=2'b00
  - SYNC=2'b01
  - DATA=2'b10
  - PARITY=2'b11
- Bit counter `cnt` holds a value in 0..max(SYNC_W, DATA_W)-1.
- Accept: `start`=1 and `ready`=1 at a rising edge.
  - Latch `data` into the shift register.
  - Compute parity p = XOR of all `data` bits (even parity).
  - Set state=SYNC and cnt=0.
- `ready` = (state==IDLE) || (state==PARITY). It is combinational from the state register.
- SYNC: `tx`=SYNC[SYNC_W-1-cnt]. When cnt reaches SYNC_W-1, go to DATA with cnt=0.
- DATA: `tx`=payload[DATA_W-1-cnt], sent MSB first. When cnt reaches DATA_W-1, go to PARITY.
- PARITY: `tx`=p and `done`=1.
  - Next state is SYNC if a new frame is accepted this cycle (gapless back-to-back).
  - Otherwise next state is IDLE.
- `start` while `ready`=0 is ignored and is not queued. `data` changes are ignored during a frame.
- `busy` = (state != IDLE).
- Frame length is SYNC_W + DATA_W + 1 cycles. With default parameters this is 13 cycles.

## Timing
- Reset, at any time including mid-frame: on the next rising edge
  - state=IDLE, cnt=0
  - `tx`=IDLE_BIT, `tx_valid`=0, `done`=0, `busy`=0, `ready`=1
  - shift register and parity cleared.
  - The partial frame is abandoned and nothing resumes after reset.
- `tx`, `tx_valid` and `done` are registered, and each is updated on the same edge as the state.
  - Let edge E0 accept `start`. Then cycles 1..SYNC_W carry sync bits, the next DATA_W cycles carry payload, and the final cycle carries parity.
  - `tx_valid`=1 for exactly those cycles.
- Latency: the first sync bit appears on `tx` one cycle after the accepting edge.
- The cycle after the parity bit, with no new start:
  - `tx`=IDLE_BIT, `tx_valid`=0, state=IDLE.
- With `start`=1 during the PARITY cycle, the next cycle is the first sync bit. `tx_valid` stays 1 with no gap.
- `start` and `reset` high on the same edge: reset wins and the frame is not accepted.
- Defaults: a 1101 detector fed from `tx` raises its registered output in the cycle after the fourth sync bit. This assumes an IDLE_BIT=0 line or an IDLE start.

## Test plan
- Reset, then idle for 5 cycles.
  - Required: `tx`=0, `tx_valid`=0, `busy`=0, `ready`=1, `done`=0, state=00 every cycle.
- `data`=8'hA5, 1-cycle `start`.
  - `tx` over cycles 1..13 = 1,1,0,1, 1,0,1,0,0,1,0,1, 0.
  - `done`=1 only in cycle 13; state=00 in cycle 14.
- `data`=8'h01, `start` held high for 20 cycles.
  - First frame: 1101, 00000001, parity 1.
  - Second frame starts in cycle 14 with no gap; `data` is sampled again at that edge.
- Start while busy: a frame with 8'hFF, plus `start` pulsed in cycle 5 with `data`=8'h00.
  - Required: the pulse is ignored; the frame is unchanged (parity 0); IDLE after cycle 13.
- Reset asserted in cycle 7 of a frame.
  - Next cycle: state=00, `tx`=0, `tx_valid`=0, `busy`=0.
  - A fresh start then produces a complete, correct frame.
- Loopback: `tx` drives a 1101 sequence detector, with 3 frames of 8'h3C.
  - Required: exactly one detector pulse per frame, each one cycle after the fourth sync bit.

Source files
------------

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial frame transmitter.
// A frame is the SYNC word (MSB first), the DATA_W-bit payload (MSB first)
// and one even-parity bit, one bit per clock on tx. Frames can be sent
// back to back with no idle gap.
//
// Handshake: the producer holds start (with data) high for as long as it
// wants to send; a frame is accepted on any rising edge where start=1 and
// ready=1, and data is captured on that same edge. start while ready=0 is
// dropped, never queued. ready is combinational from the state register.
module sync_frame_tx #(
   parameter int                DATA_W   = 8,
   parameter int                SYNC_W   = 4,
   parameter logic [SYNC_W-1:0] SYNC     = 4'b1101,
   parameter logic              IDLE_BIT = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data,
   output logic              ready,
   output logic              busy,
   output logic              tx,
   output logic              tx_valid,
   output logic              done,
   output logic [1:0]        state
);

   localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_SYNC   = 2'b01,
      S_DATA   = 2'b10,
      S_PARITY = 2'b11
   } state_t;

   state_t            state_q, next_state;
   logic [CNT_W-1:0]  cnt, next_cnt;
   logic [SYNC_W-1:0] sync_sh;
   logic [DATA_W-1:0] data_sh;
   logic              parity;
   logic              accept;
   logic              tx_d, tx_valid_d, done_d;
   logic              sync_shift, data_shift;

   assign state  = state_q;
   assign ready  = (state_q == S_IDLE) || (state_q == S_PARITY);
   assign busy   = (state_q != S_IDLE);
   assign accept = start && ready;

   // State register, bit counter and registered line outputs; reset wins over start.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt      <= '0;
         tx       <= IDLE_BIT;
         tx_valid <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= next_state;
         cnt      <= next_cnt;
         tx       <= tx_d;
         tx_valid <= tx_valid_d;
         done     <= done_d;
      end
   end

   // Payload/sync shift registers and parity; the MSB is consumed as it is emitted.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_sh <= '0;
         data_sh <= '0;
         parity  <= 1'b0;
      end else if (accept) begin
         sync_sh <= SYNC << 1;
         data_sh <= data;
         parity  <= ^data;
      end else begin
         if (sync_shift) sync_sh <= sync_sh << 1;
         if (data_shift) data_sh <= data_sh << 1;
      end
   end

   // Next-state and counter sequencing through sync, payload and parity.
   always_comb begin
      next_state = state_q;
      next_cnt   = cnt;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               next_state = S_SYNC;
               next_cnt   = '0;
            end
         end
         S_SYNC: begin
            if (cnt == SYNC_LAST) begin
               next_state = S_DATA;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt == DATA_LAST) begin
               next_state = S_PARITY;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         S_PARITY: begin
            next_state = accept ? S_SYNC : S_IDLE;
            next_cnt   = '0;
         end
         default: begin
            next_state = S_IDLE;
            next_cnt   = '0;
         end
      endcase
   end

   // Line outputs are computed for the state being entered so they register on the same edge.
   always_comb begin
      tx_d       = IDLE_BIT;
      tx_valid_d = 1'b0;
      done_d     = 1'b0;
      sync_shift = 1'b0;
      data_shift = 1'b0;
      case (next_state)
         S_SYNC: begin
            tx_valid_d = 1'b1;
            if (accept) begin
               tx_d = SYNC[SYNC_W-1];
            end else begin
               tx_d       = sync_sh[SYNC_W-1];
               sync_shift = 1'b1;
            end
         end
         S_DATA: begin
            tx_valid_d = 1'b1;
            tx_d       = data_sh[DATA_W-1];
            data_shift = 1'b1;
         end
         S_PARITY: begin
            tx_valid_d = 1'b1;
            tx_d       = parity;
            done_d     = 1'b1;
         end
         default: begin
            tx_d = IDLE_BIT;
         end
      endcase
   end

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: bench for sync_frame_tx with default parameters.
// Expected line activity comes from a frame model: a frame is the
// concatenation {SYNC, payload, ^payload}, and cycle k of a frame carries
// bit k (counting from the MSB of that concatenation).
module tb_sync_frame_tx;

   localparam int         DATA_W   = 8;
   localparam int         SYNC_W   = 4;
   localparam logic [3:0] SYNC     = 4'b1101;
   localparam logic       IDLE_BIT = 1'b0;
   localparam int         FL       = SYNC_W + DATA_W + 1;

   // clock / reset
   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [DATA_W-1:0] data;
   logic              ready, busy, tx, tx_valid, done;
   logic [1:0]        state;

   always #5 clk = ~clk;

   sync_frame_tx #(
      .DATA_W  (DATA_W),
      .SYNC_W  (SYNC_W),
      .SYNC    (SYNC),
      .IDLE_BIT(IDLE_BIT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .data    (data),
      .ready   (ready),
      .busy    (busy),
      .tx      (tx),
      .tx_valid(tx_valid),
      .done    (done),
      .state   (state)
   );

   // Receiving-end 1101 detector with a registered output, fed from tx.
   logic [3:0] det_hist;
   logic       det;
   always @(posedge clk) begin
      if (reset) begin
         det_hist <= 4'b0;
         det      <= 1'b0;
      end else begin
         det_hist <= {det_hist[2:0], tx};
         det      <= ({det_hist[2:0], tx} == 4'b1101);
      end
   end

   int         n_run  = 0;
   int         n_fail = 0;
   logic [6:0] obs, expv;

   // Frame model: sync word, payload MSB first, even parity.
   function automatic logic [FL-1:0] frame_model(input logic [DATA_W-1:0] d);
      return {SYNC, d, ^d};
   endfunction

   // Expected {state,ready,busy,done,tx_valid,tx} at position pos of a frame (0 = idle).
   function automatic logic [6:0] model_out(input int pos, input logic [FL-1:0] fr);
      logic [FL-1:0] sh;
      logic          b;
      logic [1:0]    st;
      if (pos == 0) begin
         st = 2'b00;
         b  = IDLE_BIT;
      end else begin
         sh = fr >> (FL - pos);
         b  = sh[0];
         if (pos <= SYNC_W)               st = 2'b01;
         else if (pos <= SYNC_W + DATA_W) st = 2'b10;
         else                             st = 2'b11;
      end
      return {st, (pos == 0) || (pos == FL), pos != 0, pos == FL, pos != 0, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      data  = '0;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         obs  = {state, ready, busy, done, tx_valid, tx};
         expv = model_out(0, '0);
         n_run++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: got %b want %b", c, obs, expv);
         end
         if (c < 4) tick();
      end
   endtask

   // Sends one frame with a 1-cycle start; optionally pulses start (with other data)
   // during cycle pulse_c of the frame. Checks cycles 1..FL and the idle cycle after.
   task automatic run_frame(input string name, input logic [DATA_W-1:0] d,
                            input logic [FL-1:0] fr, input int pulse_c,
                            input logic [DATA_W-1:0] pulse_d);
      start = 1'b1;
      data  = d;
      tick();
      start = 1'b0;
      data  = DATA_W'($urandom);
      for (int pos = 1; pos <= FL + 1; pos++) begin
         obs  = {state, ready, busy, done, tx_valid, tx};
         expv = model_out((pos > FL) ? 0 : pos, fr);
         n_run++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b want %b", name, pos, obs, expv);
         end
         if (pos == pulse_c) begin
            start = 1'b1;
            data  = pulse_d;
         end else begin
            start = 1'b0;
            data  = DATA_W'($urandom);
         end
         if (pos <= FL) tick();
      end
      start = 1'b0;
   endtask

   task automatic test_a5();
      run_frame("frame_a5", 8'hA5, 13'b1101_10100101_0, 0, '0);
   endtask

   task automatic test_start_while_busy();
      run_frame("start_busy", 8'hFF, frame_model(8'hFF), 5, 8'h00);
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] d;
      int                gap;
      for (int f = 0; f < 6; f++) begin
         d = DATA_W'($urandom);
         run_frame("random", d, frame_model(d), 0, '0);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            tick();
            obs  = {state, ready, busy, done, tx_valid, tx};
            expv = model_out(0, '0);
            n_run++;
            if (obs !== expv) begin
               n_fail++;
               $display("FAIL random_gap frame %0d: got %b want %b", f, obs, expv);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] d2;
      logic [FL-1:0]     fr1, fr2, fr;
      int                pos;
      d2    = DATA_W'($urandom);
      fr1   = 13'b1101_00000001_1;
      fr2   = frame_model(d2);
      start = 1'b1;
      data  = 8'h01;
      tick();
      for (int c = 1; c <= 2 * FL + 1; c++) begin
         if (c <= FL) begin
            pos = c;
            fr  = fr1;
         end else if (c <= 2 * FL) begin
            pos = c - FL;
            fr  = fr2;
         end else begin
            pos = 0;
            fr  = '0;
         end
         obs  = {state, ready, busy, done, tx_valid, tx};
         expv = model_out(pos, fr);
         n_run++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL back_to_back cycle %0d: got %b want %b", c, obs, expv);
         end
         if (c == FL) data = d2;
         else if (c < FL) data = DATA_W'($urandom);
         if (c == 20) start = 1'b0;
         if (c <= 2 * FL) tick();
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [DATA_W-1:0] d;
      logic [FL-1:0]     fr;
      d     = DATA_W'($urandom);
      fr    = frame_model(d);
      start = 1'b1;
      data  = d;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         obs  = {state, ready, busy, done, tx_valid, tx};
         expv = model_out(c, fr);
         n_run++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL reset_mid_pre cycle %0d: got %b want %b", c, obs, expv);
         end
         if (c < 7) tick();
      end
      // reset and start together during cycle 7: reset must win
      reset = 1'b1;
      start = 1'b1;
      data  = DATA_W'($urandom);
      tick();
      reset = 1'b0;
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         obs  = {state, ready, busy, done, tx_valid, tx};
         expv = model_out(0, '0);
         n_run++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL reset_mid_after cycle %0d: got %b want %b", c, obs, expv);
         end
         if (c < 2) tick();
      end
      d = DATA_W'($urandom);
      run_frame("reset_mid_fresh", d, frame_model(d), 0, '0);
   endtask

   task automatic test_loopback();
      logic [FL-1:0] fr;
      int            pos;
      int            pulses;
      logic          det_exp;
      reset = 1'b1;
      start = 1'b0;
      tick();
      reset  = 1'b0;
      fr     = frame_model(8'h3C);
      pulses = 0;
      start  = 1'b1;
      data   = 8'h3C;
      tick();
      for (int c = 1; c <= 3 * FL + 1; c++) begin
         pos  = (c > 3 * FL) ? 0 : ((c - 1) % FL) + 1;
         obs  = {state, ready, busy, done, tx_valid, tx};
         expv = model_out(pos, fr);
         n_run++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL loopback_line cycle %0d: got %b want %b", c, obs, expv);
         end
         det_exp = (c == SYNC_W + 1) || (c == FL + SYNC_W + 1) || (c == 2 * FL + SYNC_W + 1);
         if (det === 1'b1) pulses++;
         n_run++;
         if (det !== det_exp) begin
            n_fail++;
            $display("FAIL loopback_det cycle %0d: got %b want %b", c, det, det_exp);
         end
         if (c == 2 * FL + 2) start = 1'b0;
         if (c <= 3 * FL) tick();
      end
      start = 1'b0;
      n_run++;
      if (pulses !== 3) begin
         n_fail++;
         $display("FAIL loopback_count: got %0d pulses want 3", pulses);
      end
   endtask

   // Watchdog: every wait is a clock tick, this only guards against a stuck clock.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      data  = '0;
      test_reset();
      test_a5();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid();
      test_random();
      test_loopback();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
